// File: rtl/sprite_pkg.sv
// sprite_pkg: life-cycle state encoding, default sheet geometry and the
// state-to-sheet-row helper shared by sprite_animator and its testbench.
package sprite_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_HIT,
        S_DYING,
        S_DEAD
    } state_t;

    localparam int SHEET_W = 360;
    localparam int ADDR_W  = 17;

    // Sprite-sheet row shown for each life-cycle state.
    function automatic logic [7:0] rowForState(input state_t s,
                                               input int rowIdle,
                                               input int rowPlay,
                                               input int rowDeath);
        logic [7:0] row;
        case (s)
            S_PLAY, S_HIT:   row = 8'(rowPlay);
            S_DYING, S_DEAD: row = 8'(rowDeath);
            default:         row = 8'(rowIdle);
        endcase
        return row;
    endfunction

endpackage

// File: rtl/sprite_if.sv
// sprite_if: groups the per-character control pulses, VGA scan position,
// sprite placement and the registered sheet address / status outputs.
// Optional mirror input exists only when SPRITE_MIRROR_EN is defined.
interface sprite_if #(
    parameter int ADDR_W  = sprite_pkg::ADDR_W,
    parameter int FRAME_W = 2
);
    logic               en;
    logic               frame_tick;
    logic               start;
    logic               hit;
    logic               kill;
    logic [9:0]         h_cnt;
    logic [9:0]         v_cnt;
    logic [8:0]         pos_x;
    logic [8:0]         pos_y;
`ifdef SPRITE_MIRROR_EN
    logic               mirror;
`endif
    logic [ADDR_W-1:0]  pixel_addr;
    logic               is_object;
    logic [FRAME_W-1:0] anim_frame;
    logic               dead;

    // Game/VGA side: drives controls and scan position, consumes the address.
    modport master (
        output en, frame_tick, start, hit, kill,
        output h_cnt, v_cnt, pos_x, pos_y,
`ifdef SPRITE_MIRROR_EN
        output mirror,
`endif
        input  pixel_addr, is_object, anim_frame, dead
    );

    // Sprite engine side.
    modport slave (
        input  en, frame_tick, start, hit, kill,
        input  h_cnt, v_cnt, pos_x, pos_y,
`ifdef SPRITE_MIRROR_EN
        input  mirror,
`endif
        output pixel_addr, is_object, anim_frame, dead
    );

endinterface

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: one-cycle pipeline from the VGA scan position to the
// sprite-sheet ROM address and the in-box / visible flag.
// With SPRITE_MIRROR_EN defined, a mirror input flips the sprite column.
module sprite_addr_gen #(
    parameter int SPR_W   = 10,
    parameter int SPR_H   = 10,
    parameter int FRAMES  = 4,
    parameter int SHEET_W = sprite_pkg::SHEET_W,
    parameter int ADDR_W  = sprite_pkg::ADDR_W,
    parameter int FRAME_W = $clog2(FRAMES),
    parameter int ROW_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         i_hCnt,
    input  logic [9:0]         i_vCnt,
    input  logic [8:0]         i_posX,
    input  logic [8:0]         i_posY,
    input  logic [FRAME_W-1:0] i_animFrame,
    input  logic [ROW_W-1:0]   i_row,
    input  logic               i_blank,
`ifdef SPRITE_MIRROR_EN
    input  logic               i_mirror,
`endif
    output logic [ADDR_W-1:0]  o_pixelAddr,
    output logic               o_isObject
);

    logic [9:0]        w_gx;
    logic [9:0]        w_gy;
    logic [9:0]        w_posX;
    logic [9:0]        w_posY;
    logic [9:0]        w_col;
    logic [9:0]        w_rowPix;
    logic              w_inBox;
    logic [31:0]       w_colTerm;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_pixelAddr;
    logic              r_isObject;

    // Game coordinates are half the VGA counts; bounds are 10 bits wide so a
    // sprite near the right/bottom edge cannot wrap its far bound to zero.
    assign w_gx    = i_hCnt >> 1;
    assign w_gy    = i_vCnt >> 1;
    assign w_posX  = {1'b0, i_posX};
    assign w_posY  = {1'b0, i_posY};
    assign w_inBox = (w_gx >= w_posX) && (w_gx < w_posX + 10'(SPR_W)) &&
                     (w_gy >= w_posY) && (w_gy < w_posY + 10'(SPR_H));
    assign w_col    = w_gx - w_posX;
    assign w_rowPix = w_gy - w_posY;

`ifdef SPRITE_MIRROR_EN
    assign w_colTerm = i_mirror ? (32'(SPR_W - 1) - 32'(w_col)) : 32'(w_col);
`else
    assign w_colTerm = 32'(w_col);
`endif

    // Frame selects the horizontal cell, row selects the sheet row band.
    assign w_addr = ADDR_W'(w_colTerm
                          + 32'(SPR_W) * 32'(i_animFrame)
                          + (32'(w_rowPix) + 32'(SPR_H) * 32'(i_row)) * 32'(SHEET_W));

    // Register address and visibility together so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pixelAddr <= '0;
            r_isObject  <= 1'b0;
        end else begin
            r_pixelAddr <= w_inBox ? w_addr : '0;
            r_isObject  <= w_inBox && !i_blank;
        end
    end

    assign o_pixelAddr = r_pixelAddr;
    assign o_isObject  = r_isObject;

endmodule

// File: rtl/sprite_animator.sv
// sprite_animator: per-character sprite engine. Sequences animation frames,
// runs the idle/play/hit-flash/dying/dead life cycle and produces the
// registered sheet ROM address plus object flag for the pixel mux.
// Optional build macro SPRITE_MIRROR_EN adds a horizontal mirror input.
module sprite_animator #(
    parameter int SPR_W      = 10,
    parameter int SPR_H      = 10,
    parameter int FRAMES     = 4,
    parameter int SHEET_W    = sprite_pkg::SHEET_W,
    parameter int ADDR_W     = sprite_pkg::ADDR_W,
    parameter int FRAME_HOLD = 8,
    parameter int HIT_TICKS  = 16,
    parameter int ROW_IDLE   = 0,
    parameter int ROW_PLAY   = 1,
    parameter int ROW_DEATH  = 2
) (
    input  logic     clk,
    input  logic     rst,
    sprite_if.slave  bus
);
    import sprite_pkg::*;

    localparam int FRAME_W = $clog2(FRAMES);
    localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int HIT_W   = ($clog2(HIT_TICKS) > 2) ? $clog2(HIT_TICKS) : 2;
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);
    localparam logic [HOLD_W-1:0]  LAST_HOLD  = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [HIT_W-1:0]   LAST_HIT   = HIT_W'(HIT_TICKS - 1);

    // The frame cells of one sheet row must fit inside the row stride.
    if (SHEET_W < SPR_W * FRAMES) begin : g_sheetCheck
        $error("sprite_animator: SHEET_W smaller than SPR_W*FRAMES");
    end
    if (FRAMES < 2 || FRAME_HOLD < 1) begin : g_paramCheck
        $error("sprite_animator: FRAMES must be >= 2 and FRAME_HOLD >= 1");
    end

    state_t             r_state;
    state_t             w_nextState;
    logic [HOLD_W-1:0]  r_holdCnt;
    logic [HOLD_W-1:0]  w_nextHold;
    logic [HIT_W-1:0]   r_hitCnt;
    logic [HIT_W-1:0]   w_nextHit;
    logic [FRAME_W-1:0] r_animFrame;
    logic [FRAME_W-1:0] w_nextFrame;
    logic               w_holdWrap;
    logic [7:0]         w_row;
    logic               w_blank;

    assign w_holdWrap = (r_holdCnt == LAST_HOLD);

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_holdCnt   <= '0;
            r_hitCnt    <= '0;
            r_animFrame <= '0;
        end else begin
            r_state     <= w_nextState;
            r_holdCnt   <= w_nextHold;
            r_hitCnt    <= w_nextHit;
            r_animFrame <= w_nextFrame;
        end
    end

    // Next-state logic; kill beats hit beats start, and a coincident
    // frame_tick is absorbed by the restarted counters rather than counted.
    always_comb begin
        w_nextState = r_state;
        w_nextHold  = r_holdCnt;
        w_nextHit   = r_hitCnt;
        w_nextFrame = r_animFrame;
        if (bus.en) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.kill) begin
                        w_nextState = S_DYING;
                        w_nextHold  = '0;
                        w_nextFrame = '0;
                    end else if (bus.start) begin
                        w_nextState = S_PLAY;
                        w_nextHold  = '0;
                        w_nextFrame = '0;
                    end
                end
                S_PLAY, S_HIT: begin
                    if (bus.kill) begin
                        w_nextState = S_DYING;
                        w_nextHold  = '0;
                        w_nextHit   = '0;
                        w_nextFrame = '0;
                    end else begin
                        if (bus.frame_tick) begin
                            if (w_holdWrap) begin
                                w_nextHold  = '0;
                                w_nextFrame = (r_animFrame == LAST_FRAME) ? '0 : r_animFrame + 1'b1;
                            end else begin
                                w_nextHold = r_holdCnt + 1'b1;
                            end
                        end
                        if (bus.hit) begin
                            w_nextState = S_HIT;
                            w_nextHit   = '0;
                        end else if (r_state == S_HIT && bus.frame_tick) begin
                            if (r_hitCnt == LAST_HIT) begin
                                w_nextState = S_PLAY;
                                w_nextHit   = '0;
                            end else begin
                                w_nextHit = r_hitCnt + 1'b1;
                            end
                        end
                    end
                end
                S_DYING: begin
                    if (bus.frame_tick) begin
                        if (w_holdWrap) begin
                            w_nextHold = '0;
                            if (r_animFrame == LAST_FRAME) begin
                                w_nextState = S_DEAD;
                            end else begin
                                w_nextFrame = r_animFrame + 1'b1;
                            end
                        end else begin
                            w_nextHold = r_holdCnt + 1'b1;
                        end
                    end
                end
                S_DEAD: begin
                    w_nextFrame = LAST_FRAME;
                end
                default: begin
                    w_nextState = S_IDLE;
                end
            endcase
        end
    end

    // Sheet row and flash/dead blanking derived from the registered state.
    assign w_row   = rowForState(r_state, ROW_IDLE, ROW_PLAY, ROW_DEATH);
    assign w_blank = (r_state == S_DEAD) || ((r_state == S_HIT) && r_hitCnt[1]);

    assign bus.anim_frame = r_animFrame;
    assign bus.dead       = (r_state == S_DEAD);

    sprite_addr_gen #(
        .SPR_W   (SPR_W),
        .SPR_H   (SPR_H),
        .FRAMES  (FRAMES),
        .SHEET_W (SHEET_W),
        .ADDR_W  (ADDR_W),
        .FRAME_W (FRAME_W),
        .ROW_W   (8)
    ) u_addrGen (
        .clk         (clk),
        .rst         (rst),
        .i_hCnt      (bus.h_cnt),
        .i_vCnt      (bus.v_cnt),
        .i_posX      (bus.pos_x),
        .i_posY      (bus.pos_y),
        .i_animFrame (r_animFrame),
        .i_row       (w_row),
        .i_blank     (w_blank),
`ifdef SPRITE_MIRROR_EN
        .i_mirror    (bus.mirror),
`endif
        .o_pixelAddr (bus.pixel_addr),
        .o_isObject  (bus.is_object)
    );

endmodule

// File: tb/tb_sprite_animator.sv
// tb_sprite_animator: directed checks of frame sequencing, address math,
// hit flash, death sequence, enable freeze and asynchronous reset.
module tb_sprite_animator;

    localparam int ADDR_W  = 17;
    localparam int FRAME_W = 2;

    logic clk;
    logic rst;
    int   compareCount = 0;
    int   failCount    = 0;

    sprite_if #(.ADDR_W(ADDR_W), .FRAME_W(FRAME_W)) bus();

    sprite_animator #(
        .SPR_W(10), .SPR_H(10), .FRAMES(4), .SHEET_W(360), .ADDR_W(ADDR_W),
        .FRAME_HOLD(8), .HIT_TICKS(16), .ROW_IDLE(0), .ROW_PLAY(1), .ROW_DEATH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n cycles, landing 1 ns after the rising edge.
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle pulses, then two cycles so the registered outputs catch up.
    task automatic applyStimulus(input logic s, input logic h, input logic k, input logic ft);
        bus.start      = s;
        bus.hit        = h;
        bus.kill       = k;
        bus.frame_tick = ft;
        waitCycles(1);
        bus.start      = 1'b0;
        bus.hit        = 1'b0;
        bus.kill       = 1'b0;
        bus.frame_tick = 1'b0;
        waitCycles(2);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic setScan(input int h, input int v);
        bus.h_cnt = 10'(h);
        bus.v_cnt = 10'(v);
        waitCycles(1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.start      = 1'b0;
        bus.hit        = 1'b0;
        bus.kill       = 1'b0;
        bus.frame_tick = 1'b0;
        bus.pos_x      = 9'd100;
        bus.pos_y      = 9'd50;
        bus.h_cnt      = 10'd206;
        bus.v_cnt      = 10'd104;
`ifdef SPRITE_MIRROR_EN
        bus.mirror     = 1'b0;
`endif
        waitCycles(3);
        checkOutput("rst_frame", 32'(bus.anim_frame), 0);
        checkOutput("rst_addr",  32'(bus.pixel_addr), 0);
        checkOutput("rst_obj",   32'(bus.is_object), 0);
        checkOutput("rst_dead",  32'(bus.dead), 0);
        rst = 1'b0;
        waitCycles(2);

        // IDLE shows row 0: 3 + 0 + 2*360.
        checkOutput("idle_addr", 32'(bus.pixel_addr), 723);
        checkOutput("idle_obj",  32'(bus.is_object), 1);

        $display("[TB] frame sequencing");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 48; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 7 || i % 8 == 0)
                checkOutput($sformatf("seq_tick%0d", i), 32'(bus.anim_frame), 32'((i / 8) % 4));
        end

        $display("[TB] address path at frame 2");
        setScan(206, 104);
        checkOutput("addr_in",      32'(bus.pixel_addr), 4343);
        checkOutput("obj_in",       32'(bus.is_object), 1);
        setScan(218, 104);
        checkOutput("addr_rightin", 32'(bus.pixel_addr), 4349);
        setScan(220, 104);
        checkOutput("addr_right",   32'(bus.pixel_addr), 0);
        checkOutput("obj_right",    32'(bus.is_object), 0);
        setScan(198, 104);
        checkOutput("obj_left",     32'(bus.is_object), 0);
        setScan(206, 118);
        checkOutput("addr_bottomin", 32'(bus.pixel_addr), 6863);
        setScan(206, 120);
        checkOutput("obj_bottom",   32'(bus.is_object), 0);
        setScan(206, 104);

        $display("[TB] hit flash with re-trigger");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("flash_t0", 32'(bus.is_object), 1);
        for (int t = 1; t <= 10; t++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("flash_t%0d", t), 32'(bus.is_object), ((t % 4) < 2) ? 1 : 0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("reflash_u0", 32'(bus.is_object), 1);
        for (int u = 1; u <= 18; u++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("reflash_u%0d", u), 32'(bus.is_object),
                        (u >= 16 || (u % 4) < 2) ? 1 : 0);
        end
        // 76 ticks since start: frame 9 mod 4, hold 4.
        checkOutput("flash_frame", 32'(bus.anim_frame), 1);

        $display("[TB] enable freeze");
        bus.en = 1'b0;
        for (int i = 0; i < 20; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("frozen_frame", 32'(bus.anim_frame), 1);
        setScan(208, 104);
        checkOutput("frozen_addr", 32'(bus.pixel_addr), 4334);
        bus.en = 1'b1;
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("resume_frame", 32'(bus.anim_frame), 2);
        for (int i = 1; i <= 8; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("resume_frame3", 32'(bus.anim_frame), 3);
        setScan(206, 104);

        $display("[TB] kill with hit on a tick");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("dying_frame", 32'(bus.anim_frame), 0);
        checkOutput("dying_dead",  32'(bus.dead), 0);
        checkOutput("dying_addr",  32'(bus.pixel_addr), 7923);
        checkOutput("dying_obj",   32'(bus.is_object), 1);
        for (int i = 1; i <= 32; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 8)
                checkOutput("dying_t8", 32'(bus.anim_frame), 1);
            if (i == 31) begin
                checkOutput("dying_t31_frame", 32'(bus.anim_frame), 3);
                checkOutput("dying_t31_dead",  32'(bus.dead), 0);
            end
        end
        checkOutput("dead_flag",  32'(bus.dead), 1);
        checkOutput("dead_frame", 32'(bus.anim_frame), 3);
        checkOutput("dead_obj",   32'(bus.is_object), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("dead_stays", 32'(bus.dead), 1);
        checkOutput("dead_frame2", 32'(bus.anim_frame), 3);
        checkOutput("dead_obj2",  32'(bus.is_object), 0);

        $display("[TB] async reset during DYING");
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("predrst_frame", 32'(bus.anim_frame), 1);
        checkOutput("predrst_addr",  32'(bus.pixel_addr), 7933);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_frame", 32'(bus.anim_frame), 0);
        checkOutput("arst_addr",  32'(bus.pixel_addr), 0);
        checkOutput("arst_obj",   32'(bus.is_object), 0);
        checkOutput("arst_dead",  32'(bus.dead), 0);
        waitCycles(1);
        rst = 1'b0;
        waitCycles(2);
        checkOutput("post_idle_addr", 32'(bus.pixel_addr), 723);
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("post_idle_frame", 32'(bus.anim_frame), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
